// File: rtl/divider_pkg.sv
// Shared definitions for the sequential signed divider: the controller
// state encoding, the default operand width and the iteration counter width.
package divider_pkg;

  // Default operand width: dividend is 2N bits, divisor/quotient/remainder N bits.
  localparam int DEFAULT_N = 8;

  // Counter width large enough to hold the iteration count 0..N.
  localparam int CNT_W = $clog2(DEFAULT_N + 1);

  // Controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    DIVIDE = 2'd2,
    FIX    = 2'd3
  } div_state_e;

  // Counter width for an arbitrary operand width.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/restoring_step.sv
// One iteration of restoring division on unsigned magnitudes: shift the
// next dividend bit into the partial remainder and subtract the divisor
// if the result stays non-negative.
module restoring_step #(
  parameter int N = 8
) (
  input  logic [N:0]   rem_i,
  input  logic         bit_i,
  input  logic [N-1:0] dmag_i,
  output logic [N:0]   rem_o,
  output logic         q_o
);

  logic [N:0]   shifted;
  logic [N+1:0] trial;

  // The partial remainder is always below the divisor magnitude, so after
  // the shift it still fits in N+1 bits; one extra bit catches the borrow.
  always_comb begin
    shifted = {rem_i[N-1:0], bit_i};
    trial   = {1'b0, shifted} - {2'b00, dmag_i};
    q_o     = ~trial[N+1];
    rem_o   = q_o ? trial[N:0] : shifted;
  end

endmodule

// File: rtl/signed_divider.sv
// Sequential signed divider (2N-bit dividend / N-bit divisor). Works on
// magnitudes with a restoring algorithm, one quotient bit per clock, and
// applies the signs at the end. Shares the valid/done handshake of the
// Booth multiplier so a controller can drive either block.
module signed_divider
  import divider_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid,
  input  logic [2*N-1:0] Dividend,
  input  logic [N-1:0]   Divisor,
  output logic [N-1:0]   Quot,
  output logic [N-1:0]   Rem,
  output logic           busy,
  output logic           done,
  output logic           div_zero,
  output logic           ovf
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);
  localparam logic [N-1:0]  QMAX_POS  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  QMAX_NEG  = {1'b1, {(N-1){1'b0}}};

  div_state_e     state_q, state_d;
  logic [2*N-1:0] dvd_q, dvd_d;
  logic [N-1:0]   dvs_q, dvs_d;
  logic [N:0]     prem_q, prem_d;
  logic [N-1:0]   low_q, low_d;
  logic [N-1:0]   dmag_q, dmag_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic           dz_q, dz_d;
  logic           ov_q, ov_d;
  logic [N-1:0]   quot_q, quot_d;
  logic [N-1:0]   rmd_q, rmd_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           div_zero_q, div_zero_d;
  logic           ovf_q, ovf_d;

  logic [N:0]     step_rem;
  logic           step_q;
  logic [2*N-1:0] amag;
  logic [N-1:0]   bmag;
  logic           range_ovf;
  logic           fix_ovf;

  // Single shared iteration datapath, reused on every DIVIDE cycle.
  restoring_step #(.N(N)) u_step (
    .rem_i  (prem_q),
    .bit_i  (low_q[N-1]),
    .dmag_i (dmag_q),
    .rem_o  (step_rem),
    .q_o    (step_q)
  );

  // Operand magnitudes and the final signed range check; the 2N-bit
  // magnitude keeps the most negative dividend representable.
  always_comb begin
    amag      = dvd_q[2*N-1] ? -dvd_q : dvd_q;
    bmag      = dvs_q[N-1] ? -dvs_q : dvs_q;
    range_ovf = (!qneg_q && (low_q > QMAX_POS)) || (qneg_q && (low_q > QMAX_NEG));
    fix_ovf   = ov_q | (~dz_q & range_ovf);
  end

  // Next-state and datapath control for the IDLE/SETUP/DIVIDE/FIX sequence.
  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    prem_d     = prem_q;
    low_d      = low_q;
    dmag_d     = dmag_q;
    cnt_d      = cnt_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    dz_d       = dz_q;
    ov_d       = ov_q;
    quot_d     = quot_q;
    rmd_d      = rmd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (valid) begin
          dvd_d   = Dividend;
          dvs_d   = Divisor;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end

      SETUP: begin
        dmag_d = bmag;
        qneg_d = dvd_q[2*N-1] ^ dvs_q[N-1];
        rneg_d = dvd_q[2*N-1];
        dz_d   = 1'b0;
        ov_d   = 1'b0;
        prem_d = {1'b0, amag[2*N-1:N]};
        low_d  = amag[N-1:0];
        cnt_d  = '0;
        if (dvs_q == '0) begin
          dz_d    = 1'b1;
          state_d = FIX;
        end else if (amag[2*N-1:N] >= bmag) begin
          ov_d    = 1'b1;
          state_d = FIX;
        end else begin
          state_d = DIVIDE;
        end
      end

      DIVIDE: begin
        prem_d = step_rem;
        low_d  = {low_q[N-2:0], step_q};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = FIX;
        end
      end

      FIX: begin
        div_zero_d = dz_q;
        ovf_d      = fix_ovf;
        if (dz_q || fix_ovf) begin
          quot_d = '0;
          rmd_d  = '0;
        end else begin
          quot_d = qneg_q ? -low_q : low_q;
          rmd_d  = rneg_q ? -prem_q[N-1:0] : prem_q[N-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dvd_q      <= '0;
      dvs_q      <= '0;
      prem_q     <= '0;
      low_q      <= '0;
      dmag_q     <= '0;
      cnt_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      ov_q       <= 1'b0;
      quot_q     <= '0;
      rmd_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      prem_q     <= prem_d;
      low_q      <= low_d;
      dmag_q     <= dmag_d;
      cnt_q      <= cnt_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      dz_q       <= dz_d;
      ov_q       <= ov_d;
      quot_q     <= quot_d;
      rmd_q      <= rmd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
    end
  end

  assign Quot     = quot_q;
  assign Rem      = rmd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign ovf      = ovf_q;

endmodule
